// File: rtl/rgmii_tx_ce_serializer_if.sv
// GMII-side byte interface between the TX MAC (master) and the RGMII serializer (slave).
// tx_ce is a one-cycle strobe from the serializer; txd/tx_en/tx_er are sampled at the
// clock edge that closes a cycle with tx_ce = 1, and are don't-care in every other cycle.
interface rgmii_tx_ce_serializer_if;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       tx_ce;

    modport master (output txd, output tx_en, output tx_er, input tx_ce);
    modport slave  (input txd, input tx_en, input tx_er, output tx_ce);
endinterface

// File: rtl/rgmii_tx_ce_serializer.sv
// RGMII TX serializer at 250 MHz: turns GMII bytes fetched by a ce strobe into SDR
// nibbles plus a generated TX clock for 1000/100/10 Mb/s, with a local reset synchroniser.
module rgmii_tx_ce_serializer (
    input  logic                           clk250_i,
    input  logic                           reset_r_lo,
    input  logic [1:0]                     speed_i,
    rgmii_tx_ce_serializer_if.slave        gmii,
    output logic                           reset_clk125_o,
    output logic                           rgmii_tx_clk_o,
    output logic [3:0]                     rgmii_txd_o,
    output logic                           rgmii_tx_ctl_o
);

    // Phase of the current byte slot: bit 1 = nibble, bit 0 = clock half.
    typedef enum logic [1:0] {
        PH_LO_CLKH = 2'b00,
        PH_LO_CLKL = 2'b01,
        PH_HI_CLKH = 2'b10,
        PH_HI_CLKL = 2'b11
    } phase_t;

    function automatic logic [5:0] half_max(input logic [1:0] spd);
        if (spd[1])      half_max = 6'd0;
        else if (spd[0]) half_max = 6'd4;
        else             half_max = 6'd49;
    endfunction

    logic [3:0] rst_sync_q;

    phase_t     phase_q, phase_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] spd_q, spd_d;
    logic [7:0] byte_q, byte_d;
    logic       en_q, en_d;
    logic       er_q, er_d;
    logic       first_q;
    logic       ce_q, ce_d;
    logic       clk_q, clk_d;
    logic       ctl_q, ctl_d;
    logic [3:0] txd_q, txd_d;

    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) rst_sync_q <= 4'hF;
        else            rst_sync_q <= {rst_sync_q[2:0], 1'b0};
    end

    // Outputs are computed from the next state, so each register shows the cycle it belongs to.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        spd_d   = spd_q;
        byte_d  = byte_q;
        en_d    = en_q;
        er_d    = er_q;
        if (ce_q) begin
            if (first_q || !gmii.tx_en) spd_d = speed_i;
            byte_d  = gmii.txd;
            en_d    = gmii.tx_en;
            er_d    = gmii.tx_er;
            phase_d = PH_LO_CLKH;
            cnt_d   = 6'd0;
        end else if (spd_q[1]) begin
            phase_d = PH_HI_CLKL;
        end else if (cnt_q == half_max(spd_q)) begin
            cnt_d = 6'd0;
            case (phase_q)
                PH_LO_CLKH: phase_d = PH_LO_CLKL;
                PH_LO_CLKL: phase_d = PH_HI_CLKH;
                PH_HI_CLKH: phase_d = PH_HI_CLKL;
                default:    phase_d = PH_LO_CLKH;
            endcase
        end else begin
            cnt_d = cnt_q + 6'd1;
        end

        txd_d = phase_d[1] ? byte_d[7:4] : byte_d[3:0];
        ctl_d = phase_d[0] ? (en_d ^ er_d) : en_d;
        clk_d = ~phase_d[0];
        if (spd_d[1]) ce_d = phase_d[1];
        else          ce_d = (phase_d == PH_HI_CLKL) && (cnt_d == half_max(spd_d));
    end

    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            phase_q <= PH_HI_CLKL;
            cnt_q   <= 6'd0;
            spd_q   <= 2'b10;
            byte_q  <= 8'd0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            first_q <= 1'b1;
            ce_q    <= 1'b0;
            clk_q   <= 1'b0;
            ctl_q   <= 1'b0;
            txd_q   <= 4'd0;
        end else if (rst_sync_q[3]) begin
            phase_q <= PH_HI_CLKL;
            cnt_q   <= 6'd0;
            spd_q   <= 2'b10;
            byte_q  <= 8'd0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            first_q <= 1'b1;
            // Raise ce together with the synchroniser release so the first free cycle fetches a byte.
            ce_q    <= ~rst_sync_q[2];
            clk_q   <= 1'b0;
            ctl_q   <= 1'b0;
            txd_q   <= 4'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            spd_q   <= spd_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            er_q    <= er_d;
            first_q <= 1'b0;
            ce_q    <= ce_d;
            clk_q   <= clk_d;
            ctl_q   <= ctl_d;
            txd_q   <= txd_d;
        end
    end

    assign reset_clk125_o = rst_sync_q[3];
    assign gmii.tx_ce     = ce_q;
    assign rgmii_tx_clk_o = clk_q;
    assign rgmii_tx_ctl_o = ctl_q;
    assign rgmii_txd_o    = txd_q;

endmodule

// File: tb/tb_rgmii_tx_ce_serializer.sv
// Bench for rgmii_tx_ce_serializer: directed and random bytes checked cycle by cycle
// against a per-byte expected output stream built from the serializer's timing rules.
`timescale 1ns/1ps
module tb_rgmii_tx_ce_serializer;

    logic       clk250_i   = 1'b0;
    logic       reset_r_lo = 1'b1;
    logic [1:0] speed_i    = 2'b10;
    logic       reset_clk125_o;
    logic       rgmii_tx_clk_o;
    logic [3:0] rgmii_txd_o;
    logic       rgmii_tx_ctl_o;

    rgmii_tx_ce_serializer_if gmii ();

    rgmii_tx_ce_serializer dut (
        .clk250_i       (clk250_i),
        .reset_r_lo     (reset_r_lo),
        .speed_i        (speed_i),
        .gmii           (gmii.slave),
        .reset_clk125_o (reset_clk125_o),
        .rgmii_tx_clk_o (rgmii_tx_clk_o),
        .rgmii_txd_o    (rgmii_txd_o),
        .rgmii_tx_ctl_o (rgmii_tx_ctl_o)
    );

    always #2 clk250_i = ~clk250_i;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle tuple {ce, clk, ctl, txd[3:0]}; 7'h7F never occurs legally.
    logic [6:0] exp_q[$];
    logic [9:0] plan_q[$];   // {er, en, byte} for directed ce cycles
    logic       m_first;
    logic [1:0] m_spd;
    bit         rand_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for one byte slot: P cycles after its ce, last cycle carries the next ce.
    task automatic push_byte(input logic [7:0] b, input logic en, input logic er);
        int  h;
        logic half, nib;
        if (m_first || !en) m_spd = speed_i;
        m_first = 1'b0;
        if (m_spd[1]) begin
            exp_q.push_back({1'b0, 1'b1, en, b[3:0]});
            exp_q.push_back({1'b1, 1'b0, en ^ er, b[7:4]});
        end else begin
            h = m_spd[0] ? 5 : 50;
            for (int k = 0; k < 4 * h; k++) begin
                half = ((k / h) % 2) == 1;
                nib  = (k >= 2 * h);
                exp_q.push_back({(k == 4 * h - 1), ~half, half ? (en ^ er) : en,
                                 nib ? b[7:4] : b[3:0]});
            end
        end
    endtask

    task automatic step();
        logic [6:0] e;
        logic [6:0] got;
        logic [9:0] t;
        int r;
        @(posedge clk250_i);
        #1;
        got = {gmii.tx_ce, rgmii_tx_clk_o, rgmii_tx_ctl_o, rgmii_txd_o};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7F;
        chk("rgmii_cycle", got, e);
        chk("rst125_low", reset_clk125_o, 1'b0);
        if (e == 7'h7F) return;
        if (e[6]) begin
            if (rand_mode) begin
                r = $urandom_range(0, 9);
                if (r == 0)      speed_i = 2'b00;
                else if (r < 4)  speed_i = 2'b01;
                else if (r < 8)  speed_i = 2'b10;
                else if (r == 8) speed_i = 2'b11;
                t = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                     8'($urandom_range(0, 255))};
            end else begin
                t = (plan_q.size() > 0) ? plan_q.pop_front() : 10'd0;
            end
            gmii.txd   = t[7:0];
            gmii.tx_en = t[8];
            gmii.tx_er = t[9];
            push_byte(t[7:0], t[8], t[9]);
        end else begin
            gmii.txd   = 8'($urandom_range(0, 255));
            gmii.tx_en = 1'($urandom_range(0, 1));
            gmii.tx_er = 1'($urandom_range(0, 1));
            if (rand_mode) speed_i = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic reset_seq();
        reset_r_lo = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(posedge clk250_i);
            #1;
            chk("in_reset_outs", {gmii.tx_ce, rgmii_tx_clk_o, rgmii_tx_ctl_o, rgmii_txd_o}, 7'd0);
            chk("in_reset_rst125", reset_clk125_o, 1'b1);
        end
        reset_r_lo = 1'b0;
        repeat (3) begin
            @(posedge clk250_i);
            #1;
            chk("sync_hold_rst125", reset_clk125_o, 1'b1);
            chk("sync_hold_outs", {gmii.tx_ce, rgmii_tx_clk_o, rgmii_tx_ctl_o, rgmii_txd_o}, 7'd0);
        end
        m_first = 1'b1;
        exp_q.push_back(7'b100_0000);
    endtask

    initial begin
        int guard;
        gmii.txd   = 8'd0;
        gmii.tx_en = 1'b0;
        gmii.tx_er = 1'b0;
        m_first    = 1'b1;
        m_spd      = 2'b10;

        // 1000 stream, error combinations, then idle
        speed_i = 2'b10;
        plan_q.push_back({1'b0, 1'b1, 8'hA5});
        plan_q.push_back({1'b0, 1'b1, 8'h3C});
        plan_q.push_back({1'b1, 1'b1, 8'h55});
        plan_q.push_back({1'b1, 1'b0, 8'h55});
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        reset_seq();
        repeat (14) step();

        // 100 mode: idle ce applies the speed, then 0x96
        speed_i = 2'b01;
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        plan_q.push_back({1'b0, 1'b1, 8'h96});
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        repeat (70) step();

        // 10 mode, then a 1000 request that must wait for the first idle ce
        speed_i = 2'b00;
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        plan_q.push_back({1'b0, 1'b1, 8'h11});
        plan_q.push_back({1'b0, 1'b1, 8'h22});
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        plan_q.push_back({1'b0, 1'b1, 8'h33});
        plan_q.push_back({1'b0, 1'b1, 8'h44});
        repeat (30) step();
        speed_i = 2'b10;
        repeat (700) step();

        // Randomized bytes, enables, errors and speed requests
        rand_mode = 1;
        repeat (8000) step();
        rand_mode = 0;

        // Reset in the middle of a 10M byte
        speed_i = 2'b00;
        plan_q.delete();
        plan_q.push_back({1'b0, 1'b0, 8'h00});
        plan_q.push_back({1'b0, 1'b1, 8'h7F});
        guard = 0;
        while (plan_q.size() > 0 && guard < 3000) begin
            step();
            guard++;
        end
        chk("plan_drained", plan_q.size(), 0);
        repeat (30) step();
        @(posedge clk250_i);
        #1;
        reset_r_lo = 1'b1;
        #0.5;
        chk("async_rst_outs", {gmii.tx_ce, rgmii_tx_clk_o, rgmii_tx_ctl_o, rgmii_txd_o}, 7'd0);
        chk("async_rst_rst125", reset_clk125_o, 1'b1);
        speed_i = 2'b10;
        plan_q.push_back({1'b0, 1'b1, 8'h5A});
        plan_q.push_back({1'b0, 1'b0, 8'hC3});
        reset_seq();
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
